// File: rtl/ppu_cmd_queue.sv
// ppu_cmd_queue: buffers PPU command words sent by the processor and presents
// them to the PPU over a valid/ready handshake. The queue holds DEPTH words in
// a circular array plus one more in the output register. Words that arrive
// while the queue is full are dropped and counted.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   ppu_send, hold  - processor send strobe; ignored while the pipeline is held
//   interface_data  - command word that accompanies ppu_send
//   cmd_valid/data  - registered command presented to the PPU
//   cmd_ready       - PPU accepts cmd_data this cycle
//   count/full/empty- occupancy (array + output register), registered
//   overflow        - sticky flag: at least one word was dropped
//   overflow_clr    - clears overflow and drop_count
//   drop_count      - dropped-word count, saturates at 255
module ppu_cmd_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ppu_send,
    input  logic                        hold,
    input  logic [WIDTH-1:0]            interface_data,
    output logic                        cmd_valid,
    output logic [WIDTH-1:0]            cmd_data,
    input  logic                        cmd_ready,
    output logic [$clog2(DEPTH+2)-1:0]  count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic [7:0]                  drop_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned ACW = $clog2(DEPTH + 1);
    localparam int unsigned CW  = $clog2(DEPTH + 2);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr,     w_wr_ptr_nxt;
    logic [AW-1:0]    r_rd_ptr,     w_rd_ptr_nxt;
    logic [ACW-1:0]   r_arr_cnt,    w_arr_cnt_nxt;
    logic             r_cmd_valid,  w_cmd_valid_nxt;
    logic [WIDTH-1:0] r_cmd_data,   w_cmd_data_nxt;
    logic [CW-1:0]    r_count,      w_count_nxt;
    logic             r_full,       w_full_nxt;
    logic             r_empty,      w_empty_nxt;
    logic             r_overflow,   w_overflow_nxt;
    logic [7:0]       r_drop_count, w_drop_count_nxt;

    logic w_push_req, w_pop, w_load, w_accept, w_drop;
    logic w_arr_rd, w_bypass, w_arr_wr;

    // Handshake decode. A full queue still accepts when the head leaves the
    // same cycle, because the head's array slot is freed for the new word.
    assign w_push_req = ppu_send & ~hold;
    assign w_pop      = r_cmd_valid & cmd_ready;
    assign w_load     = ~r_cmd_valid | w_pop;
    assign w_accept   = w_push_req & (~r_full | w_pop);
    assign w_drop     = w_push_req & ~w_accept;
    assign w_arr_rd   = w_load & (r_arr_cnt != '0);
    // Bypass only with an empty array so ordering is preserved.
    assign w_bypass   = w_load & (r_arr_cnt == '0) & w_accept;
    assign w_arr_wr   = w_accept & ~w_bypass;

    // Next-state computation for pointers, output register, occupancy and drops.
    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_cmd_valid_nxt  = r_cmd_valid;
        w_cmd_data_nxt   = r_cmd_data;
        w_overflow_nxt   = r_overflow;
        w_drop_count_nxt = r_drop_count;

        if (w_load) begin
            w_cmd_valid_nxt = w_arr_rd | w_bypass;
            if (w_arr_rd) begin
                w_cmd_data_nxt = r_mem[r_rd_ptr];
                w_rd_ptr_nxt   = r_rd_ptr + AW'(1);
            end else if (w_bypass) begin
                w_cmd_data_nxt = interface_data;
            end
        end

        if (w_arr_wr) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        end

        w_arr_cnt_nxt = r_arr_cnt + ACW'(w_arr_wr) - ACW'(w_arr_rd);
        w_count_nxt   = CW'(w_arr_cnt_nxt) + CW'(w_cmd_valid_nxt);
        w_full_nxt    = (w_count_nxt == CW'(DEPTH + 1));
        w_empty_nxt   = (w_count_nxt == '0);

        // A drop in the clearing cycle wins over the clear.
        if (overflow_clr) begin
            w_overflow_nxt   = w_drop;
            w_drop_count_nxt = 8'(w_drop);
        end else if (w_drop) begin
            w_overflow_nxt = 1'b1;
            if (r_drop_count != 8'hFF) begin
                w_drop_count_nxt = r_drop_count + 8'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_arr_cnt    <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_data   <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_arr_cnt    <= w_arr_cnt_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_cmd_data   <= w_cmd_data_nxt;
            r_count      <= w_count_nxt;
            r_full       <= w_full_nxt;
            r_empty      <= w_empty_nxt;
            r_overflow   <= w_overflow_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_arr_wr) begin
            r_mem[r_wr_ptr] <= interface_data;
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_data   = r_cmd_data;
    assign count      = r_count;
    assign full       = r_full;
    assign empty      = r_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
